// File: rtl/mc_cu_pkg.sv
// Shared constants for the multicycle control unit: FSM state encodings,
// opcode and function-field values, and ALU operation codes.
package mc_cu_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC_R = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_EXEC_I = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_JR     = 4'd11,
    ST_JAL    = 4'd12,
    ST_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  // States that wait on the memory handshake and are covered by the timeout.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_dec.sv
// Combinational instruction decoder: maps (op_code, func) to the ALU
// operation used in the execute stage and flags whether the instruction is
// supported. bne is only recognised when MC_CU_BNE_EN is defined.
module mc_alu_dec
  import mc_cu_pkg::*;
(
  input  logic [5:0] op_code_i,
  input  logic [5:0] func_i,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);

  // Opcode/function lookup; unknown encodings leave legal_o low.
  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b0;
    case (op_code_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD: begin alu_op_o = ALU_ADD; legal_o = 1'b1; end
          FN_AND: begin alu_op_o = ALU_AND; legal_o = 1'b1; end
          FN_OR:  begin alu_op_o = ALU_OR;  legal_o = 1'b1; end
          FN_NOR: begin alu_op_o = ALU_NOR; legal_o = 1'b1; end
          FN_SLT: begin alu_op_o = ALU_SLT; legal_o = 1'b1; end
          FN_SLL: begin alu_op_o = ALU_SLL; legal_o = 1'b1; end
          FN_JR:  legal_o = 1'b1;
          default: legal_o = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_J, OP_JAL: legal_o = 1'b1;
      OP_BEQ:  begin alu_op_o = ALU_SUB; legal_o = 1'b1; end
`ifdef MC_CU_BNE_EN
      OP_BNE:  begin alu_op_o = ALU_SUB; legal_o = 1'b1; end
`endif
      OP_ADDI: begin alu_op_o = ALU_ADD; legal_o = 1'b1; end
      OP_ANDI: begin alu_op_o = ALU_AND; legal_o = 1'b1; end
      OP_ORI:  begin alu_op_o = ALU_OR;  legal_o = 1'b1; end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-style control unit (Moore FSM) with a memory-wait timeout
// that traps. Optional macro MC_CU_BNE_EN adds bne decoding and the
// pc_cond_inv output; without it op_code 0x05 traps.
module mc_control_unit
  import mc_cu_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op_code,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               JumpAndLink,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
`ifdef MC_CU_BNE_EN
  output logic               pc_cond_inv,
`endif
  output logic [3:0]         state,
  output logic               illegal
);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] alu_q;
  logic       rdst_q, store_q;
  logic [3:0] dec_alu_op;
  logic       dec_legal;
  logic       timeout;
  logic [3:0] alu_sel;
  logic       pcw, pcc, mwr, rw;

  mc_alu_dec u_alu_dec (
    .op_code_i (op_code),
    .func_i    (func),
    .alu_op_o  (dec_alu_op),
    .legal_o   (dec_legal)
  );

`ifdef MC_CU_BNE_EN
  logic bne_q;
  // Remember whether the branch being executed is bne.
  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE) bne_q <= (op_code == OP_BNE);
  end
  assign pc_cond_inv = (state_q == ST_BRANCH) && bne_q;
`else
  logic unused_zero;
  assign unused_zero = zero;
`endif

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Memory wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  // Latch the decoded instruction attributes once, in DECODE.
  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE) begin
      alu_q   <= dec_alu_op;
      rdst_q  <= (op_code == OP_RTYPE);
      store_q <= (op_code == OP_SW);
    end
  end

  // Next-state logic, including the memory timeout and decode dispatch.
  always_comb begin
    state_d = state_q;
    timeout = (wait_q == 8'(MEM_TIMEOUT)) && !mem_ready;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE; else if (timeout) state_d = ST_TRAP;
      ST_DECODE: begin
        if (!dec_legal) state_d = ST_TRAP;
        else begin
          case (op_code)
            OP_LW, OP_SW:           state_d = ST_MEMADR;
            OP_RTYPE:               state_d = (func == FN_JR) ? ST_JR : ST_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_EXEC_I;
`ifdef MC_CU_BNE_EN
            OP_BEQ, OP_BNE:         state_d = ST_BRANCH;
`else
            OP_BEQ:                 state_d = ST_BRANCH;
`endif
            OP_J:                   state_d = ST_JUMP;
            OP_JAL:                 state_d = ST_JAL;
            default:                state_d = ST_TRAP;
          endcase
        end
      end
      ST_MEMADR: state_d = store_q ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB; else if (timeout) state_d = ST_TRAP;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH; else if (timeout) state_d = ST_TRAP;
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALUWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_JR, ST_JAL: state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_TRAP;
    endcase
    // Clear on entry to a wait state, count stalled cycles while in one.
    wait_d = wait_q;
    if ((state_d != state_q) && is_wait_state(state_d)) wait_d = '0;
    else if (is_wait_state(state_q) && !mem_ready)       wait_d = wait_q + 8'd1;
  end

  // Output decode from the state register; only FETCH looks at mem_ready.
  always_comb begin
    pcw = 1'b0; pcc = 1'b0; mwr = 1'b0; rw = 1'b0;
    IorD = 1'b0; MemRead = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0;
    RegDst = 1'b0; ALUSrcA = 1'b0; JumpAndLink = 1'b0;
    ALUSrcB = 2'd0; PCSource = 2'd0; alu_sel = ALU_AND; illegal = 1'b0;
    case (state_q)
      ST_FETCH:  begin MemRead = 1'b1; IRWrite = mem_ready; pcw = mem_ready;
                       ALUSrcB = 2'd1; alu_sel = ALU_ADD; end
      ST_DECODE: begin ALUSrcB = 2'd3; alu_sel = ALU_ADD; end
      ST_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; alu_sel = ALU_ADD; end
      ST_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
      ST_MEMWR:  begin mwr = 1'b1; IorD = 1'b1; end
      ST_MEMWB:  begin rw = 1'b1; MemtoReg = 1'b1; end
      ST_EXEC_R: begin ALUSrcA = 1'b1; alu_sel = alu_q; end
      ST_EXEC_I: begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; alu_sel = alu_q; end
      ST_ALUWB:  begin rw = 1'b1; RegDst = rdst_q; end
      ST_BRANCH: begin
        ALUSrcA = 1'b1; alu_sel = ALU_SUB; PCSource = 2'd1;
`ifdef MC_CU_BNE_EN
        pcc = bne_q ? ~zero : zero;
`else
        pcc = 1'b1;
`endif
      end
      ST_JUMP:   begin pcw = 1'b1; PCSource = 2'd2; end
      ST_JR:     begin pcw = 1'b1; PCSource = 2'd3; end
      ST_JAL:    begin pcw = 1'b1; PCSource = 2'd2; rw = 1'b1; JumpAndLink = 1'b1; end
      ST_TRAP:   illegal = 1'b1;
      default:   illegal = 1'b0;
    endcase
  end

  // Write strobes are held off for as long as reset is asserted.
  assign PCWrite     = pcw & ~reset;
  assign PCWriteCond = pcc & ~reset;
  assign MemWrite    = mwr & ~reset;
  assign RegWrite    = rw  & ~reset;
  assign ALUOp       = ALUOP_W'(alu_sel);
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit with a per-cycle expectation scoreboard.
// Define MC_CU_BNE_EN when building to exercise the bne variant.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op_code = 6'h00, func = 6'h00;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic RegDst, RegWrite, ALUSrcA, JumpAndLink, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, state;
`ifdef MC_CU_BNE_EN
  logic pc_cond_inv;
`endif

  mc_control_unit #(.ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .func(func), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .JumpAndLink(JumpAndLink), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp),
`ifdef MC_CU_BNE_EN
    .pc_cond_inv(pc_cond_inv),
`endif
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [19:0] ctrl;
    logic       inv;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] cur_alu = 4'b0010;
  logic cur_rdst = 1'b0, cur_bne = 1'b0;

  logic [5:0] rfn  [5] = '{6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
  logic [3:0] ralu [5] = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111};
  logic [5:0] iop  [3] = '{6'h08, 6'h0C, 6'h0D};
  logic [3:0] ialu [3] = '{4'b0010, 4'b0000, 4'b0001};

  // Reference outputs for a state, packed in the same order as the observed vector.
  function automatic logic [19:0] model(input logic [3:0] st, input logic mr,
                                        input logic z, input logic rst);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal, ill;
    logic [1:0] bsel, psrc;
    logic [3:0] aop;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal, ill} = '0;
    bsel = 2'd0; psrc = 2'd0; aop = 4'd0;
    case (st)
      4'd0:  begin mrd = 1; irw = mr; pcw = mr; bsel = 2'd1; aop = 4'b0010; end
      4'd1:  begin bsel = 2'd3; aop = 4'b0010; end
      4'd2:  begin asa = 1; bsel = 2'd2; aop = 4'b0010; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = cur_alu; end
      4'd7:  begin rw = 1; rdst = cur_rdst; end
      4'd8:  begin asa = 1; bsel = 2'd2; aop = cur_alu; end
      4'd9:  begin
        asa = 1; aop = 4'b0110; psrc = 2'd1;
`ifdef MC_CU_BNE_EN
        pcc = cur_bne ? ~z : z;
`else
        pcc = 1'b1;
`endif
      end
      4'd10: begin pcw = 1; psrc = 2'd2; end
      4'd11: begin pcw = 1; psrc = 2'd3; end
      4'd12: begin pcw = 1; psrc = 2'd2; rw = 1; jal = 1; end
      4'd15: ill = 1;
      default: ill = 0;
    endcase
    if (rst) begin mwr = 0; rw = 0; pcw = 0; pcc = 0; ill = 0; end
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal,
            bsel, psrc, aop, ill};
  endfunction

  task automatic check(input exp_t e);
    logic [19:0] obs;
    obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, JumpAndLink, ALUSrcB, PCSource, ALUOp, illegal};
    vectors++;
    assert (state === e.st) else begin
      miscompares++;
      $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
    end
    vectors++;
    assert (obs === e.ctrl) else begin
      miscompares++;
      $error("FAIL %s controls: observed %05h expected %05h", e.tag, obs, e.ctrl);
    end
`ifdef MC_CU_BNE_EN
    vectors++;
    assert (pc_cond_inv === e.inv) else begin
      miscompares++;
      $error("FAIL %s pc_cond_inv: observed %0b expected %0b", e.tag, pc_cond_inv, e.inv);
    end
`endif
  endtask

  // One clock cycle: drive inputs on the falling edge, expect state est.
  task automatic cyc(input logic mr, input logic z, input logic [3:0] est, input string tag);
    exp_t e;
    @(negedge clk);
    reset = 1'b0; mem_ready = mr; zero = z;
    e.tag = tag; e.st = est; e.ctrl = model(est, mr, z, 1'b0);
    e.inv = (est == 4'd9) && cur_bne;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check(e);
  endtask

  // Assert reset mid-cycle and check it across a clock edge; released by the next cyc.
  task automatic rst_pulse(input string tag);
    exp_t e;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    e.tag = tag; e.st = 4'd0; e.ctrl = model(4'd0, 1'b1, zero, 1'b1); e.inv = 1'b0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check(e);
    @(posedge clk);
    #1;
    e.tag = {tag, "_hold"}; e.st = 4'd0; e.ctrl = model(4'd0, 1'b1, zero, 1'b1); e.inv = 1'b0;
    sb.push_back(e);
    e = sb.pop_front();
    check(e);
  endtask

  task automatic setinst(input logic [5:0] op, input logic [5:0] fn,
                         input logic [3:0] alu, input logic rd, input logic bne);
    op_code = op; func = fn; cur_alu = alu; cur_rdst = rd; cur_bne = bne;
  endtask

  initial begin
    rst_pulse("reset");

    setinst(6'h23, 6'h00, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "lw_fetch"); cyc(1, 0, 1, "lw_decode"); cyc(1, 0, 2, "lw_memadr");
    cyc(1, 0, 3, "lw_memrd"); cyc(1, 0, 4, "lw_memwb");

    setinst(6'h00, 6'h20, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, "add_fetch_stall");
    cyc(1, 0, 0, "add_fetch"); cyc(1, 0, 1, "add_decode");
    cyc(1, 0, 6, "add_exec"); cyc(1, 0, 7, "add_wb");

    for (int i = 0; i < 5; i++) begin
      setinst(6'h00, rfn[i], ralu[i], 1'b1, 1'b0);
      cyc(1, 0, 0, "r_fetch"); cyc(1, 0, 1, "r_decode");
      cyc(1, 0, 6, "r_exec"); cyc(1, 0, 7, "r_wb");
    end

    for (int i = 0; i < 3; i++) begin
      setinst(iop[i], 6'h00, ialu[i], 1'b0, 1'b0);
      cyc(1, 0, 0, "i_fetch"); cyc(1, 0, 1, "i_decode");
      cyc(1, 0, 8, "i_exec"); cyc(1, 0, 7, "i_wb");
    end

    setinst(6'h23, 6'h00, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "lwwait_fetch"); cyc(1, 0, 1, "lwwait_decode"); cyc(1, 0, 2, "lwwait_memadr");
    cyc(0, 0, 3, "lwwait_stall"); cyc(0, 0, 3, "lwwait_stall");
    cyc(1, 0, 3, "lwwait_memrd"); cyc(1, 0, 4, "lwwait_memwb");

    setinst(6'h04, 6'h00, 4'b0110, 1'b0, 1'b0);
    cyc(1, 0, 0, "beq_fetch"); cyc(1, 0, 1, "beq_decode"); cyc(1, 1, 9, "beq_z1");
    cyc(1, 0, 0, "beq_fetch"); cyc(1, 0, 1, "beq_decode"); cyc(1, 0, 9, "beq_z0");

    setinst(6'h02, 6'h00, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "j_fetch"); cyc(1, 0, 1, "j_decode"); cyc(1, 0, 10, "j_jump");
    setinst(6'h03, 6'h00, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "jal_fetch"); cyc(1, 0, 1, "jal_decode"); cyc(1, 0, 12, "jal_jal");
    setinst(6'h00, 6'h08, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "jr_fetch"); cyc(1, 0, 1, "jr_decode"); cyc(1, 0, 11, "jr_jr");

    // mem_ready arriving on the cycle the counter hits the limit still completes.
    setinst(6'h2B, 6'h00, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "swlast_fetch"); cyc(1, 0, 1, "swlast_decode"); cyc(1, 0, 2, "swlast_memadr");
    for (int i = 0; i < 15; i++) cyc(0, 0, 5, "swlast_stall");
    cyc(1, 0, 5, "swlast_complete");

    cyc(1, 0, 0, "swto_fetch"); cyc(1, 0, 1, "swto_decode"); cyc(1, 0, 2, "swto_memadr");
    for (int i = 0; i < 16; i++) cyc(0, 0, 5, "swto_stall");
    cyc(1, 0, 15, "swto_trap"); cyc(1, 0, 15, "swto_trap_hold");
    rst_pulse("swto_reset");

    setinst(6'h3F, 6'h00, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "bad_fetch"); cyc(1, 0, 1, "bad_decode");
    cyc(1, 0, 15, "bad_trap"); cyc(1, 0, 15, "bad_trap_hold");
    rst_pulse("bad_reset");

`ifdef MC_CU_BNE_EN
    setinst(6'h05, 6'h00, 4'b0110, 1'b0, 1'b1);
    cyc(1, 0, 0, "bne_fetch"); cyc(1, 0, 1, "bne_decode"); cyc(1, 0, 9, "bne_z0");
    cyc(1, 0, 0, "bne_fetch"); cyc(1, 0, 1, "bne_decode"); cyc(1, 1, 9, "bne_z1");
`else
    setinst(6'h05, 6'h00, 4'b0110, 1'b0, 1'b0);
    cyc(1, 0, 0, "bne_fetch"); cyc(1, 0, 1, "bne_decode"); cyc(1, 0, 15, "bne_trap");
    rst_pulse("bne_reset");
`endif

    setinst(6'h2B, 6'h00, 4'b0010, 1'b0, 1'b0);
    cyc(1, 0, 0, "swrst_fetch"); cyc(1, 0, 1, "swrst_decode"); cyc(1, 0, 2, "swrst_memadr");
    cyc(0, 0, 5, "swrst_memwr"); cyc(0, 0, 5, "swrst_memwr");
    rst_pulse("swrst_reset");
    cyc(1, 0, 0, "swrst_refetch"); cyc(1, 0, 1, "swrst_redecode");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
